trap_sequencer: RTL and testbench

Receives the synchronous exception report from the Execute stage (valid, cause, tval) and the MRET indication, and runs the machine-mode trap entry/return sequence. It owns the trap CSRs (mstatus MIE/MPIE, mtvec, mscratch, mepc, mcause, mtval), serves their read/write port, and drives pipeline flush, stall and PC redirect toward the front end.

---
 rtl/trap_sequencer.sv | 150 +++++++++++++++
 tb/tb_trap_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry/return sequencer: owns the trap CSRs and steers
// flush, stall and fetch redirect through a three-state IDLE/FLUSH/REDIRECT walk.
module trap_sequencer #(
  parameter int unsigned      XLEN              = 32,
  parameter logic [XLEN-1:0]  TRAP_VECTOR_RESET = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_exception_valid,
  input  logic [XLEN-1:0] i_exception_cause,
  input  logic [XLEN-1:0] i_exception_tval,
  input  logic [XLEN-1:0] i_exception_pc,
  input  logic            i_is_mret,
  input  logic            i_stall,
  input  logic            i_csr_we,
  input  logic [11:0]     i_csr_addr,
  input  logic [XLEN-1:0] i_csr_wdata,
  output logic [XLEN-1:0] o_csr_rdata,
  output logic            o_flush,
  output logic            o_trap_stall,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_trap_taken,
  output logic            o_mie
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  typedef struct packed {
    logic            vld;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic [XLEN-1:0] pc;
  } exc_req_t;

  state_t          state, state_nxt;
  exc_req_t        exc;
  logic            accept_exc, accept_mret, csr_wr_en;
  logic            mie, mpie;
  logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mtval, target;

  assign exc = '{vld: i_exception_valid, cause: i_exception_cause,
                 tval: i_exception_tval, pc: i_exception_pc};

  // Exception beats MRET; neither is consumed while the pipeline is stalled.
  always_comb begin
    state_nxt   = state;
    accept_exc  = 1'b0;
    accept_mret = 1'b0;
    case (state)
      IDLE: begin
        if (!i_stall) begin
          if (exc.vld) begin
            accept_exc = 1'b1;
            state_nxt  = FLUSH;
          end else if (i_is_mret) begin
            accept_mret = 1'b1;
            state_nxt   = FLUSH;
          end
        end
      end
      FLUSH:    state_nxt = REDIRECT;
      REDIRECT: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // A faulting instruction must not commit its own CSR write.
  assign csr_wr_en = i_csr_we && !i_stall && (state == IDLE) && !exc.vld;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= IDLE;
      mie              <= 1'b0;
      mpie             <= 1'b0;
      mtvec            <= {TRAP_VECTOR_RESET[XLEN-1:2], 2'b00};
      mscratch         <= '0;
      mepc             <= '0;
      mcause           <= '0;
      mtval            <= '0;
      target           <= '0;
      o_flush          <= 1'b0;
      o_trap_stall     <= 1'b0;
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= '0;
      o_trap_taken     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (csr_wr_en) begin
        case (i_csr_addr)
          ADDR_MSTATUS: begin
            mie  <= i_csr_wdata[3];
            mpie <= i_csr_wdata[7];
          end
          ADDR_MTVEC:    mtvec    <= {i_csr_wdata[XLEN-1:2], 2'b00};
          ADDR_MSCRATCH: mscratch <= i_csr_wdata;
          ADDR_MEPC:     mepc     <= {i_csr_wdata[XLEN-1:1], 1'b0};
          ADDR_MCAUSE:   mcause   <= i_csr_wdata;
          ADDR_MTVAL:    mtval    <= i_csr_wdata;
          default: ;
        endcase
      end
      // Placed after the CSR write so an MRET overrides a same-cycle mstatus write.
      if (accept_exc) begin
        mepc   <= {exc.pc[XLEN-1:1], 1'b0};
        mcause <= exc.cause;
        mtval  <= exc.tval;
        mpie   <= mie;
        mie    <= 1'b0;
        target <= {mtvec[XLEN-1:2], 2'b00};
      end else if (accept_mret) begin
        mie    <= mpie;
        mpie   <= 1'b1;
        target <= mepc;
      end
      o_flush          <= (state_nxt == FLUSH);
      o_trap_stall     <= (state_nxt != IDLE);
      o_redirect_valid <= (state_nxt == REDIRECT);
      o_redirect_pc    <= (state_nxt == REDIRECT) ? target : '0;
      o_trap_taken     <= accept_exc;
    end
  end

  assign o_mie = mie;

  always_comb begin
    o_csr_rdata = '0;
    case (i_csr_addr)
      ADDR_MSTATUS: begin
        o_csr_rdata[3]     = mie;
        o_csr_rdata[7]     = mpie;
        o_csr_rdata[12:11] = 2'b11;
      end
      ADDR_MTVEC:    o_csr_rdata = mtvec;
      ADDR_MSCRATCH: o_csr_rdata = mscratch;
      ADDR_MEPC:     o_csr_rdata = mepc;
      ADDR_MCAUSE:   o_csr_rdata = mcause;
      ADDR_MTVAL:    o_csr_rdata = mtval;
      default:       o_csr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: reset, ECALL, MRET, exception/MRET
// collision, stall hold, write suppression and reset mid-sequence.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid, is_mret, stall, csr_we;
  logic [31:0] exc_cause, exc_tval, exc_pc, csr_wdata, csr_rdata, redirect_pc;
  logic [11:0] csr_addr;
  logic        flush, trap_stall, redirect_valid, trap_taken, mie;

  int checks = 0;
  int errors = 0;

  trap_sequencer #(.XLEN(32), .TRAP_VECTOR_RESET(32'h8000_0103)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_exception_valid(exc_valid), .i_exception_cause(exc_cause),
    .i_exception_tval(exc_tval), .i_exception_pc(exc_pc),
    .i_is_mret(is_mret), .i_stall(stall),
    .i_csr_we(csr_we), .i_csr_addr(csr_addr), .i_csr_wdata(csr_wdata),
    .o_csr_rdata(csr_rdata), .o_flush(flush), .o_trap_stall(trap_stall),
    .o_redirect_valid(redirect_valid), .o_redirect_pc(redirect_pc),
    .o_trap_taken(trap_taken), .o_mie(mie)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs then change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr = addr;
    #1;
    chk(tag, csr_rdata, exp);
  endtask

  task automatic strobes(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, trap_taken, flush, trap_stall, redirect_valid, mie}, {27'd0, exp});
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    csr_we = 1'b1; csr_addr = addr; csr_wdata = data;
    step();
    csr_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; exc_valid = 0; is_mret = 0; stall = 0; csr_we = 0;
    exc_cause = 0; exc_tval = 0; exc_pc = 0; csr_wdata = 0; csr_addr = 0;
    step(); step();
    // {trap_taken, flush, trap_stall, redirect_valid, mie}
    strobes("rst_strobes", 5'b00000);
    chk("rst_rpc", redirect_pc, 32'h0);
    rd("rst_mtvec", 12'h305, 32'h8000_0100);
    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    rd("rst_mepc", 12'h341, 32'h0);
    rst = 1'b0;
    step();

    wr(12'h305, 32'h0000_0203);
    wr(12'h300, 32'h0000_0008);
    rd("set_mtvec", 12'h305, 32'h0000_0200);
    rd("set_mstatus", 12'h300, 32'h0000_1808);
    wr(12'h7C0, 32'h1234_5678);
    rd("unmapped", 12'h7C0, 32'h0);

    // ECALL
    exc_valid = 1; exc_cause = 11; exc_tval = 0; exc_pc = 32'h0000_1005;
    step();
    exc_valid = 0;
    strobes("ecall_n0", 5'b11100);
    rd("ecall_mcause_n0", 12'h342, 32'd11);
    step();
    strobes("ecall_n1", 5'b00110);
    chk("ecall_rpc", redirect_pc, 32'h0000_0200);
    step();
    strobes("ecall_n2", 5'b00000);
    chk("ecall_rpc_idle", redirect_pc, 32'h0);
    rd("ecall_mepc", 12'h341, 32'h0000_1004);
    rd("ecall_mstatus", 12'h300, 32'h0000_1880);

    // MRET, with a colliding mstatus write that must lose
    is_mret = 1; csr_we = 1; csr_addr = 12'h300; csr_wdata = 32'h0;
    step();
    is_mret = 0; csr_we = 0;
    strobes("mret_n0", 5'b01101);
    rd("mret_mstatus", 12'h300, 32'h0000_1888);
    step();
    strobes("mret_n1", 5'b00111);
    chk("mret_rpc", redirect_pc, 32'h0000_1004);
    step();
    strobes("mret_n2", 5'b00001);

    // exception and MRET together
    exc_valid = 1; is_mret = 1; exc_cause = 4; exc_tval = 32'h0000_3001; exc_pc = 32'h0000_2000;
    step();
    exc_valid = 0; is_mret = 0;
    strobes("both_n0", 5'b11100);
    step();
    chk("both_rpc", redirect_pc, 32'h0000_0200);
    step();
    rd("both_mcause", 12'h342, 32'd4);
    rd("both_mtval", 12'h343, 32'h0000_3001);
    rd("both_mstatus", 12'h300, 32'h0000_1880);

    // stall hold with a suppressed mscratch write
    exc_valid = 1; exc_cause = 2; exc_tval = 0; exc_pc = 32'h0000_3000; stall = 1;
    csr_we = 1; csr_addr = 12'h340; csr_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_flush", {31'd0, flush}, 32'd0);
    end
    stall = 0;
    step();
    csr_we = 0;
    strobes("stall_n0", 5'b11100);
    rd("stall_mscratch", 12'h340, 32'h0);
    // second exception during FLUSH is ignored
    exc_cause = 7; exc_pc = 32'h0000_4000;
    step();
    exc_valid = 0;
    strobes("flush_ign_n1", 5'b00110);
    step();
    strobes("flush_ign_n2", 5'b00000);
    rd("flush_ign_mcause", 12'h342, 32'd2);
    rd("flush_ign_mepc", 12'h341, 32'h0000_3000);

    // reset during FLUSH
    exc_valid = 1; exc_cause = 5; exc_pc = 32'h0000_5000;
    step();
    exc_valid = 0;
    chk("rmid_flush", {31'd0, flush}, 32'd1);
    rst = 1;
    step();
    strobes("rmid_n1", 5'b00000);
    rd("rmid_mepc", 12'h341, 32'h0);
    rst = 0;
    step();
    strobes("rmid_n2", 5'b00000);
    rd("rmid_mtvec", 12'h305, 32'h8000_0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
